// File: rtl/simplex_angle_extract_if.sv
// Handshake bundle between simplex_angle_extract and the shared vectoring CORDIC.
// The master side issues operands and a start pulse; the slave side returns magnitude/angle.
`timescale 1ns/1ps
interface simplex_angle_extract_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int ANGLE_WIDTH = 16
);
  logic                          cordic_vec_en;
  logic signed [DATA_WIDTH-1:0]  cordic_vec_xin_reg;
  logic signed [DATA_WIDTH-1:0]  cordic_vec_yin_reg;
  logic signed [DATA_WIDTH-1:0]  cordic_vec_xout;
  logic signed [ANGLE_WIDTH-1:0] cordic_vec_angle_out;
  logic                          cordic_vec_opvld;

  modport master (
    output cordic_vec_en, cordic_vec_xin_reg, cordic_vec_yin_reg,
    input  cordic_vec_xout, cordic_vec_angle_out, cordic_vec_opvld
  );

  modport slave (
    input  cordic_vec_en, cordic_vec_xin_reg, cordic_vec_yin_reg,
    output cordic_vec_xout, cordic_vec_angle_out, cordic_vec_opvld
  );
endinterface

// File: rtl/simplex_angle_extract.sv
// Reduces one N_DIM vector to its N_DIM-1 hyperspherical angles through a shared
// vectoring CORDIC and stores them into one slot of the GSO angle bank.
`timescale 1ns/1ps
module simplex_angle_extract #(
  parameter int DATA_WIDTH  = 16,
  parameter int ANGLE_WIDTH = 16,
  parameter int N_DIM       = 7
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        en,
  input  logic [2:0]                                  j_in,
  input  logic                                        clear,
  input  logic [DATA_WIDTH*N_DIM-1:0]                 w_in_flat,
  simplex_angle_extract_if.master                     cordic,
  output logic [ANGLE_WIDTH*(N_DIM-1)*(N_DIM-1)-1:0]  thetas_out_flat,
  output logic [DATA_WIDTH-1:0]                       norm_out,
  output logic                                        busy,
  output logic                                        done,
  output logic                                        err
);

  localparam int         K    = N_DIM - 1;
  localparam logic [2:0] K_M1 = 3'(K - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_VEC_EN,
    S_VEC_WAIT,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic signed [DATA_WIDTH-1:0]  r_w    [N_DIM];
  logic        [2:0]             r_j;
  logic        [2:0]             r_level;
  logic signed [DATA_WIDTH-1:0]  r_mag;
  logic signed [ANGLE_WIDTH-1:0] r_bank [K][K];
  logic        [DATA_WIDTH-1:0]  r_norm;
  logic                          r_err;
  logic                          r_done;
  logic                          r_busy;
  logic                          r_vec_en;
  logic signed [DATA_WIDTH-1:0]  r_xin;
  logic signed [DATA_WIDTH-1:0]  r_yin;

  logic       w_accept_en;
  logic       w_clear_bank;
  logic       w_load;
  logic       w_j_bad;
  logic       w_issue;
  logic       w_capture;
  logic       w_last;
  logic [2:0] w_xsel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (en) w_state_nxt = S_LOAD;
      S_LOAD:     w_state_nxt = w_j_bad ? S_DONE : S_VEC_EN;
      S_VEC_EN:   w_state_nxt = S_VEC_WAIT;
      S_VEC_WAIT: if (cordic.cordic_vec_opvld) w_state_nxt = w_last ? S_DONE : S_VEC_EN;
      S_DONE:     w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_accept_en  = (r_state == S_IDLE) && en;
    w_clear_bank = (r_state == S_IDLE) && clear;
    w_load       = (r_state == S_LOAD);
    w_j_bad      = (j_in > K_M1);
    w_issue      = (r_state == S_VEC_EN);
    w_capture    = (r_state == S_VEC_WAIT) && cordic.cordic_vec_opvld;
    w_last       = (r_level == K_M1);
    w_xsel       = r_level + 3'd1;
  end

  // Level 0 vectors (w0,w1); later levels fold the running magnitude in as y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_DIM; i++) r_w[i] <= '0;
      for (int unsigned a = 0; a < K; a++)
        for (int unsigned b = 0; b < K; b++) r_bank[a][b] <= '0;
      r_j      <= '0;
      r_level  <= '0;
      r_mag    <= '0;
      r_norm   <= '0;
      r_err    <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_vec_en <= 1'b0;
      r_xin    <= '0;
      r_yin    <= '0;
    end else begin
      r_done   <= (w_state_nxt == S_DONE);
      r_busy   <= (w_state_nxt != S_IDLE);
      r_vec_en <= w_issue;

      if (w_accept_en)           r_err <= 1'b0;
      else if (w_load && w_j_bad) r_err <= 1'b1;

      if (w_load) begin
        for (int unsigned i = 0; i < N_DIM; i++)
          r_w[i] <= w_in_flat[i*DATA_WIDTH +: DATA_WIDTH];
        r_j     <= j_in;
        r_level <= '0;
      end

      if (w_issue) begin
        if (r_level == 3'd0) begin
          r_xin <= r_w[0];
          r_yin <= r_w[1];
        end else begin
          r_xin <= r_w[w_xsel];
          r_yin <= r_mag;
        end
      end

      if (w_clear_bank) begin
        for (int unsigned a = 0; a < K; a++)
          for (int unsigned b = 0; b < K; b++) r_bank[a][b] <= '0;
      end else if (w_capture) begin
        r_bank[r_j][r_level] <= cordic.cordic_vec_angle_out;
      end

      if (w_capture) begin
        r_mag <= cordic.cordic_vec_xout;
        if (w_last) r_norm  <= cordic.cordic_vec_xout;
        else        r_level <= r_level + 3'd1;
      end
    end
  end

  always_comb begin
    thetas_out_flat = '0;
    for (int unsigned a = 0; a < K; a++)
      for (int unsigned b = 0; b < K; b++)
        thetas_out_flat[(a*K+b)*ANGLE_WIDTH +: ANGLE_WIDTH] = r_bank[a][b];
  end

  assign cordic.cordic_vec_en      = r_vec_en;
  assign cordic.cordic_vec_xin_reg = r_xin;
  assign cordic.cordic_vec_yin_reg = r_yin;
  assign norm_out                  = r_norm;
  assign busy                      = r_busy;
  assign done                      = r_done;
  assign err                       = r_err;

endmodule

// File: tb/tb_simplex_angle_extract.sv
// Scoreboarded bench for simplex_angle_extract with a real-valued CORDIC stand-in (latency 4)
// and a hyperspherical-angle reference computed from exact partial norms.
`timescale 1ns/1ps
module tb_simplex_angle_extract;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int N  = 7;
  localparam int K  = N - 1;
  localparam int L  = 4;
  localparam int BW = AW*K*K;
  localparam real PI = 3.14159265358979323846;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           en;
  logic [2:0]     j_in;
  logic           clear;
  logic [DW*N-1:0] w_in_flat;
  logic [BW-1:0]  thetas_out_flat;
  logic [DW-1:0]  norm_out;
  logic           busy, done, err;

  simplex_angle_extract_if #(.DATA_WIDTH(DW), .ANGLE_WIDTH(AW)) cif ();

  simplex_angle_extract #(.DATA_WIDTH(DW), .ANGLE_WIDTH(AW), .N_DIM(N)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en              (en),
    .j_in            (j_in),
    .clear           (clear),
    .w_in_flat       (w_in_flat),
    .cordic          (cif),
    .thetas_out_flat (thetas_out_flat),
    .norm_out        (norm_out),
    .busy            (busy),
    .done            (done),
    .err             (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int en_pulses = 0;
  bit spur = 1'b0;

  bit              exp_err_q [$];
  int              exp_norm_q[$];
  logic [BW-1:0]   exp_bank_q[$];
  int              mbank [K][K];

  function automatic int ang_code(real a);
    int c;
    c = int'($floor(a * 32768.0 / PI + 0.5));
    if (c >= 32768) c -= 65536;
    return c;
  endfunction

  function automatic int mag_code(real m);
    int c;
    c = int'($floor(m + 0.5));
    if (c > 32767) c = 32767;
    return c;
  endfunction

  function automatic bit near(logic [15:0] a, logic [15:0] b);
    logic signed [15:0] d;
    d = a - b;
    return (d <= 16'sd2) && (d >= -16'sd2);
  endfunction

  function automatic logic [BW-1:0] flat_bank();
    logic [BW-1:0] f;
    f = '0;
    for (int a = 0; a < K; a++)
      for (int b = 0; b < K; b++) f[(a*K+b)*AW +: AW] = AW'(mbank[a][b]);
    return f;
  endfunction

  function automatic logic [DW*N-1:0] rand_vec();
    logic [DW*N-1:0] v;
    int m;
    for (int i = 0; i < N; i++) begin
      m = int'($urandom_range(12000, 4096));
      if ($urandom_range(1, 0) == 1) m = -m;
      v[i*DW +: DW] = DW'(m);
    end
    return v;
  endfunction

  // External vectoring CORDIC stand-in
  task automatic cordic_serve();
    real x, y;
    x = real'(int'(signed'(cif.cordic_vec_xin_reg)));
    y = real'(int'(signed'(cif.cordic_vec_yin_reg)));
    en_pulses++;
    repeat (L) @(posedge clk);
    #1;
    cif.cordic_vec_opvld     = 1'b1;
    cif.cordic_vec_xout      = DW'(mag_code($sqrt(x*x + y*y)));
    cif.cordic_vec_angle_out = AW'(ang_code($atan2(y, x)));
    @(posedge clk);
    #1;
    if (spur) begin
      cif.cordic_vec_xout      = 16'h7123;
      cif.cordic_vec_angle_out = 16'h5555;
      @(posedge clk);
      #1;
    end
    cif.cordic_vec_opvld = 1'b0;
  endtask

  initial begin
    cif.cordic_vec_opvld     = 1'b0;
    cif.cordic_vec_xout      = '0;
    cif.cordic_vec_angle_out = '0;
    forever begin
      @(posedge clk);
      #1;
      while (cif.cordic_vec_en) cordic_serve();
    end
  end

  task automatic check_done();
    bit            e_err;
    int            e_norm;
    logic [BW-1:0] e_bank;
    int            bad_idx;
    n_cmp++;
    if (exp_err_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_done: done=1 with no pending run (expected none)");
      return;
    end
    e_err  = exp_err_q.pop_front();
    e_norm = exp_norm_q.pop_front();
    e_bank = exp_bank_q.pop_front();
    if (err !== e_err) begin
      n_bad++;
      $display("FAIL err_at_done: got %0b expected %0b", err, e_err);
    end
    if (!e_err) begin
      n_cmp++;
      if (!near(norm_out, 16'(e_norm))) begin
        n_bad++;
        $display("FAIL norm: got %0h expected %0h (+-2)", norm_out, 16'(e_norm));
      end
    end
    n_cmp++;
    bad_idx = -1;
    for (int i = 0; i < K*K; i++)
      if (bad_idx < 0 && !near(thetas_out_flat[i*AW +: AW], e_bank[i*AW +: AW])) bad_idx = i;
    if (bad_idx >= 0) begin
      n_bad++;
      $display("FAIL bank[%0d][%0d]: got %0h expected %0h (+-2)", bad_idx / K, bad_idx % K,
               thetas_out_flat[bad_idx*AW +: AW], e_bank[bad_idx*AW +: AW]);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (done) check_done();
    end
  end

  task automatic run_vec(input logic [DW*N-1:0] wf, input int j, input bit with_clear,
                         input bit mid_en, input bit spur_en, input int exp_lat);
    real s;
    real wv [N];
    int  cnt;
    int  pulses0;
    bit  e_err;
    int  e_norm;
    for (int i = 0; i < N; i++) wv[i] = real'(int'(signed'(wf[i*DW +: DW])));
    if (with_clear)
      for (int a = 0; a < K; a++)
        for (int b = 0; b < K; b++) mbank[a][b] = 0;
    e_err  = (j >= K);
    e_norm = 0;
    if (!e_err) begin
      mbank[j][0] = ang_code($atan2(wv[1], wv[0]));
      s = wv[0]*wv[0] + wv[1]*wv[1];
      for (int l = 1; l < K; l++) begin
        mbank[j][l] = ang_code($atan2($sqrt(s), wv[l+1]));
        s += wv[l+1]*wv[l+1];
      end
      e_norm = mag_code($sqrt(s));
    end
    exp_err_q.push_back(e_err);
    exp_norm_q.push_back(e_norm);
    exp_bank_q.push_back(flat_bank());

    pulses0   = en_pulses;
    spur      = spur_en;
    w_in_flat = wf;
    j_in      = 3'(j);
    clear     = with_clear;
    en        = 1'b1;
    @(posedge clk);
    #1;
    en    = 1'b0;
    clear = 1'b0;
    cnt   = 1;
    while (!done && cnt < 300) begin
      @(posedge clk);
      #1;
      cnt++;
      if (mid_en && cnt == 10) begin
        en        = 1'b1;
        j_in      = 3'd5;
        w_in_flat = rand_vec();
      end
      if (mid_en && cnt == 11) en = 1'b0;
      if (mid_en && cnt == 12) clear = 1'b1;
      if (mid_en && cnt == 13) clear = 1'b0;
    end
    n_cmp++;
    if (!done || cnt != exp_lat) begin
      n_bad++;
      $display("FAIL done_latency: got %0d cycles (done=%0b) expected %0d", cnt, done, exp_lat);
    end
    if (e_err) begin
      n_cmp++;
      if (en_pulses != pulses0) begin
        n_bad++;
        $display("FAIL err_no_cordic: got %0d cordic starts expected 0", en_pulses - pulses0);
      end
    end
    spur = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW*N-1:0] v;
    int pulses0;
    int cnt;

    for (int a = 0; a < K; a++)
      for (int b = 0; b < K; b++) mbank[a][b] = 0;
    rst_n = 1'b0; en = 1'b0; clear = 1'b0; j_in = '0; w_in_flat = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, err, cif.cordic_vec_en} !== 4'b0 || norm_out !== '0 || thetas_out_flat !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got busy=%0b done=%0b err=%0b vec_en=%0b norm=%0h bank_nonzero=%0b expected all 0",
               busy, done, err, cif.cordic_vec_en, norm_out, |thetas_out_flat);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    v = '0; v[0*DW +: DW] = 16'h4000;
    run_vec(v, 0, 1'b0, 1'b0, 1'b0, 2 + K*(L+2));
    v = '0; v[1*DW +: DW] = 16'h4000;
    run_vec(v, 2, 1'b0, 1'b0, 1'b0, 2 + K*(L+2));
    for (int i = 0; i < N; i++) v[i*DW +: DW] = 16'h2000;
    run_vec(v, 1, 1'b0, 1'b0, 1'b0, 2 + K*(L+2));

    run_vec(rand_vec(), 6, 1'b0, 1'b0, 1'b0, 2);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (err !== 1'b1) begin
      n_bad++;
      $display("FAIL err_held: got %0b expected 1", err);
    end

    v = rand_vec();
    run_vec(v, 3, 1'b0, 1'b1, 1'b1, 2 + K*(L+2));
    run_vec(v, 3, 1'b0, 1'b0, 1'b0, 2 + K*(L+2));

    for (int r = 0; r < 6; r++)
      run_vec(rand_vec(), int'($urandom_range(K-1, 0)), 1'b0, 1'b0, 1'b0, 2 + K*(L+2));

    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    for (int a = 0; a < K; a++)
      for (int b = 0; b < K; b++) mbank[a][b] = 0;
    n_cmp++;
    if (thetas_out_flat !== '0) begin
      n_bad++;
      $display("FAIL clear_bank: got nonzero bank (or=%0b) expected all 0", |thetas_out_flat);
    end

    run_vec(rand_vec(), 4, 1'b1, 1'b0, 1'b0, 2 + K*(L+2));
    run_vec(rand_vec(), 4, 1'b1, 1'b0, 1'b0, 2 + K*(L+2));

    // Abort during level 3
    pulses0   = en_pulses;
    w_in_flat = rand_vec();
    j_in      = 3'd5;
    en        = 1'b1;
    @(posedge clk);
    #1;
    en  = 1'b0;
    cnt = 0;
    while (en_pulses < pulses0 + 4 && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    n_cmp++;
    if (en_pulses < pulses0 + 4) begin
      n_bad++;
      $display("FAIL reach_level3: got %0d cordic starts expected 4", en_pulses - pulses0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    for (int a = 0; a < K; a++)
      for (int b = 0; b < K; b++) mbank[a][b] = 0;
    n_cmp++;
    if (thetas_out_flat !== '0 || busy !== 1'b0 || cif.cordic_vec_en !== 1'b0 || norm_out !== '0) begin
      n_bad++;
      $display("FAIL reset_midrun: got bank_nonzero=%0b busy=%0b vec_en=%0b norm=%0h expected all 0",
               |thetas_out_flat, busy, cif.cordic_vec_en, norm_out);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    n_cmp++;
    if (thetas_out_flat !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL post_abort_idle: got bank_nonzero=%0b busy=%0b done=%0b expected all 0",
               |thetas_out_flat, busy, done);
    end

    run_vec(rand_vec(), 0, 1'b0, 1'b0, 1'b0, 2 + K*(L+2));

    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (exp_err_q.size() != 0) begin
      n_bad++;
      $display("FAIL pending_runs: got %0d undelivered expected 0", exp_err_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
